ins_decode_n32: RTL and testbench
=================================

# ins_decode_n32

Instruction-decode stage for the 32-bit MIPS datapath, directly downstream of instruction fetch. It captures `im_out_ins` in an IF/ID pipeline register and extracts the register and immediate fields. It decodes the supported subset (addu, subu, ori, lw, sw, beq, lui, j) into datapath controls, and returns `npc_sel` / `isJump` / immediates to fetch. It also detects load-use hazards, freezing fetch and inserting one bubble.

## Interface
Parameters:
- `W_INS`, 32, instruction width (fixed; checked at elaboration).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_id_n`  in  1  asynchronous, active-low reset.
- `if_ins`  in  32  instruction from fetch.
- `if_valid`  in  1  `if_ins` is meaningful this cycle.
- `id_stall`  in  1  downstream hold; IF/ID register keeps its contents.
- `id_flush`  in  1  downstream kill; IF/ID register becomes a bubble.
- `fetch_hold`  out  1  freeze PC this cycle (load-use stall).
- `id_ins`  out  32  registered instruction.
- `id_valid`  out  1  `id_ins` is a live, issuing instruction.
- `rs`, `rt`, `rd`  out  5 each  register fields `[25:21]`, `[20:16]`, `[15:11]`.
- `npc_in_imm16`  out  16  bits `[15:0]`.
- `npc_in_imm26`  out  26  bits `[25:0]`.
- `npc_sel`  out  1  issuing instruction is beq.
- `isJump`  out  1  issuing instruction is j.
- `reg_write`  out  1  register-file write enable.
- `reg_dst`  out  1  register-file destination select: 1 = `rd`, 0 = `rt`.
- `alu_src`  out  1  ALU operand B select: 1 = extended immediate.
- `mem_read`  out  1  data-memory read enable.
- `mem_write`  out  1  data-memory write enable.
- `mem_to_reg`  out  1  write-back data select: 1 = memory data.
- `ext_op`  out  2  0 ZERO, 1 SIGN, 2 HIGH (imm16 << 16).
- `alu_op`  out  3  0 ADD, 1 SUB, 2 OR, 3 LUI.
- `id_illegal`  out  1  unsupported encoding (see Configuration).

## Operation
- IF/ID register update priority on each edge: reset > `id_flush` > `id_stall` > load-use hazard > load.
  - Flush: `id_ins` ← 0, `id_valid` ← 0.
  - Stall or hazard: hold.
  - Load: `id_ins` ← `if_ins`, `id_valid` ← `if_valid`.
- Field outputs are always driven from `id_ins`.
- Control outputs are combinational from `id_ins`. All controls are forced to 0 when any of these hold: `!id_valid`, state is LU_STALL, `id_stall`, or `id_flush`.
- Decode table:
  - addu (op 0, funct 0x21): `reg_write`, `reg_dst`, ADD.
  - subu (op 0, funct 0x23): `reg_write`, `reg_dst`, SUB.
  - ori (0x0D): `reg_write`, `alu_src`, ZERO, OR.
  - lw (0x23): `reg_write`, `alu_src`, `mem_read`, `mem_to_reg`, SIGN, ADD.
  - sw (0x2B): `alu_src`, `mem_write`, SIGN, ADD.
  - beq (0x04): `npc_sel`, SIGN, SUB.
  - lui (0x0F): `reg_write`, `alu_src`, HIGH, LUI.
  - j (0x02): `isJump`.
  - All-zero word: legal NOP, all controls 0.
- Load-use tracker: a registered `ex_lw` flag and `ex_lw_rt`. Updated every edge when not `id_stall`. It captures whether the instruction issued this cycle is lw, and its `rt`. A bubble clears the flag.
- Hazard condition: `ex_lw` is set, `ex_lw_rt` ≠ 0, and the current instruction reads `ex_lw_rt`:
  - Reads `rs`: all except j, lui, NOP.
  - Reads `rt`: addu, subu, sw, beq.
- FSM:
  - RUN → LU_STALL on hazard. In LU_STALL: bubble controls, `fetch_hold` = 1.
  - LU_STALL → RUN unconditionally after one cycle. The held instruction then issues.
  - `id_flush` in either state → RUN.
  - `id_stall` freezes the state.

## Timing
- Reset (asynchronous, immediate):
  - `id_ins` = 0, `id_valid` = 0, all controls 0.
  - `fetch_hold` = 0, `id_illegal` = 0.
  - State RUN, tracker cleared.
- Latency: `if_ins` sampled at edge N; its decoded controls are valid during cycle N→N+1.
- `fetch_hold` is combinational; it is asserted in the same cycle as the hazard is detected.
- A load-use pair costs exactly one extra cycle. Back-to-back lw→lw→use stalls only on the dependent pair.
- Simultaneous `id_flush` and hazard: the flush wins, and `fetch_hold` = 0.
- Reset asserted mid-stall aborts it; the first instruction after release decodes normally.

## Configuration
- `ID_ILLEGAL_TRAP_EN` defined:
  - Any encoding outside the decode table with `id_valid` = 1 asserts `id_illegal`.
  - That instruction issues as a bubble.
- Not defined:
  - `id_illegal` is tied to 0.
  - Unknown encodings decode as NOP.

## Structure
- Shared package `mips_pkg` holds:
  - Opcode and funct constants.
  - `alu_op` and `ext_op` encodings.
  - The FSM state typedef (RUN, LU_STALL).
- One sub-module `ins_ctrl_dec`: purely combinational opcode/funct → control bundle, reused by a future single-cycle top.

## Test plan
- Reset: drop `rst_id_n` mid-run with `id_ins` = 0x00221821 → immediately `id_valid` = 0, `id_ins` = 0, all controls 0.
- addu 0x00221821 → after one edge: `rs` = 1, `rt` = 2, `rd` = 3, `reg_write` = 1, `reg_dst` = 1, `alu_op` = ADD.
- lw 0x8C220004 followed by addu 0x00421821:
  - One cycle with `fetch_hold` = 1 and controls 0.
  - Next cycle: addu issues with `rs` = 2.
  - `$0` variant 0x8C200004 → no stall.
- beq 0x1022FFFE → `npc_sel` = 1, `npc_in_imm16` = 0xFFFE, `ext_op` = SIGN, `alu_op` = SUB.
- j 0x08000010 → `isJump` = 1, `npc_in_imm26` = 0x0000010. Assert `id_flush` next cycle → `id_valid` = 0, controls 0.
- With `ID_ILLEGAL_TRAP_EN`: 0xFC000000 → `id_illegal` = 1, controls 0. Without it: `id_illegal` = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS decode slice.
//   - opcode / funct constants for the supported subset
//   - alu_op / ext_op encodings
//   - decode-stage FSM state type
//   - ctrl_t: datapath control bundle produced by ins_ctrl_dec
//   - src_regs(): which register fields an instruction reads
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_OR  = 3'd2,
    ALU_LUI = 3'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'd0,
    EXT_SIGN = 2'd1,
    EXT_HIGH = 2'd2
  } ext_op_e;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } id_state_e;

  typedef struct packed {
    logic    npc_sel;
    logic    is_jump;
    logic    reg_write;
    logic    reg_dst;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    ext_op_e ext_op;
    alu_op_e alu_op;
  } ctrl_t;

  // Returns {reads_rs, reads_rt}. Unknown encodings and the NOP read nothing.
  function automatic logic [1:0] src_regs(input logic [5:0] op, input logic [5:0] funct);
    logic [1:0] src;
    src = 2'b00;
    case (op)
      OP_RTYPE:       src = (funct == FN_ADDU || funct == FN_SUBU) ? 2'b11 : 2'b00;
      OP_ORI, OP_LW:  src = 2'b10;
      OP_SW, OP_BEQ:  src = 2'b11;
      default:        src = 2'b00;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/ins_ctrl_dec.sv
// ins_ctrl_dec: purely combinational opcode/funct -> control bundle.
// Ports:
//   op       in  6   instruction [31:26]
//   funct    in  6   instruction [5:0]
//   all_zero in  1   whole instruction word is zero (NOP)
//   ctrl     out     control bundle, all zero for NOP / unknown
//   legal    out 1   encoding is in the supported subset (NOP included)
module ins_ctrl_dec
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       all_zero,
  output ctrl_t      ctrl,
  output logic       legal
);

  always_comb begin
    ctrl  = '0;
    legal = 1'b1;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_ADDU) begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
          ctrl.alu_op    = ALU_ADD;
        end else if (funct == FN_SUBU) begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
          ctrl.alu_op    = ALU_SUB;
        end else if (!all_zero) begin
          legal = 1'b0;
        end
      end
      OP_ORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.ext_op    = EXT_ZERO;
        ctrl.alu_op    = ALU_OR;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.ext_op     = EXT_SIGN;
        ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.ext_op    = EXT_SIGN;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.npc_sel = 1'b1;
        ctrl.ext_op  = EXT_SIGN;
        ctrl.alu_op  = ALU_SUB;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.ext_op    = EXT_HIGH;
        ctrl.alu_op    = ALU_LUI;
      end
      OP_J: begin
        ctrl.is_jump = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ins_decode_n32.sv
// ins_decode_n32: MIPS instruction-decode stage (IF/ID register, field
// extraction, control decode, load-use stall).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue from the IF/ID register
// LU_STALL | one-cycle load-use bubble; IF/ID held, fetch frozen
//
// Ports:
//   clk, rst_id_n            clock, async active-low reset
//   if_ins/if_valid          instruction from fetch
//   id_stall/id_flush        downstream hold / kill
//   fetch_hold               freeze PC (load-use stall)
//   id_ins/id_valid          IF/ID register contents
//   rs/rt/rd, npc_in_imm16/26 instruction fields
//   npc_sel..alu_op          datapath controls (zero when not issuing)
//   id_illegal               unsupported encoding (trap build only)
// Build option: define ID_ILLEGAL_TRAP_EN to flag unknown encodings and
// issue them as bubbles; otherwise they decode as NOP.
module ins_decode_n32
  import mips_pkg::*;
#(
  parameter int W_INS = 32
) (
  input  logic             clk,
  input  logic             rst_id_n,
  input  logic [W_INS-1:0] if_ins,
  input  logic             if_valid,
  input  logic             id_stall,
  input  logic             id_flush,
  output logic             fetch_hold,
  output logic [W_INS-1:0] id_ins,
  output logic             id_valid,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [15:0]      npc_in_imm16,
  output logic [25:0]      npc_in_imm26,
  output logic             npc_sel,
  output logic             isJump,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic [1:0]       ext_op,
  output logic [2:0]       alu_op,
  output logic             id_illegal
);

  if (W_INS != 32) begin : g_w_ins_check
    $error("ins_decode_n32: W_INS must be 32");
  end

  id_state_e  state_q, state_d;
  ctrl_t      dec_ctrl, ctrl_out;
  logic       dec_legal;
  logic       trap_ok;
  logic       stalling, issue, load_en;
  logic       ex_lw, ex_lw_d;
  logic [4:0] ex_lw_rt, ex_lw_rt_d;
  logic [1:0] id_src, if_src;
  logic       hazard, haz_ahead;

  assign rs           = id_ins[25:21];
  assign rt           = id_ins[20:16];
  assign rd           = id_ins[15:11];
  assign npc_in_imm16 = id_ins[15:0];
  assign npc_in_imm26 = id_ins[25:0];

  ins_ctrl_dec u_ctrl_dec (
    .op       (id_ins[31:26]),
    .funct    (id_ins[5:0]),
    .all_zero (id_ins == '0),
    .ctrl     (dec_ctrl),
    .legal    (dec_legal)
  );

`ifdef ID_ILLEGAL_TRAP_EN
  assign trap_ok    = dec_legal;
  assign id_illegal = id_valid && !dec_legal;
`else
  logic unused_dec_legal;
  assign unused_dec_legal = dec_legal;
  assign trap_ok          = 1'b1;
  assign id_illegal       = 1'b0;
`endif

  assign stalling = (state_q == LU_STALL);
  assign issue    = id_valid && trap_ok && !stalling && !id_stall && !id_flush;
  assign load_en  = !id_flush && !id_stall && !stalling;

  always_comb begin
    ctrl_out = '0;
    if (issue) ctrl_out = dec_ctrl;
  end

  assign npc_sel    = ctrl_out.npc_sel;
  assign isJump     = ctrl_out.is_jump;
  assign reg_write  = ctrl_out.reg_write;
  assign reg_dst    = ctrl_out.reg_dst;
  assign alu_src    = ctrl_out.alu_src;
  assign mem_read   = ctrl_out.mem_read;
  assign mem_write  = ctrl_out.mem_write;
  assign mem_to_reg = ctrl_out.mem_to_reg;
  assign ext_op     = ctrl_out.ext_op;
  assign alu_op     = ctrl_out.alu_op;

  // Tracker contents for the next cycle: the lw issuing right now.
  assign ex_lw_d    = issue && dec_ctrl.mem_read;
  assign ex_lw_rt_d = ex_lw_d ? rt : 5'd0;

  assign id_src = src_regs(id_ins[31:26], id_ins[5:0]);
  assign hazard = ex_lw && (ex_lw_rt != 5'd0) &&
                  ((id_src[1] && rs == ex_lw_rt) || (id_src[0] && rt == ex_lw_rt));

  // The dependency is checked against the instruction being loaded, so the
  // stall state lines up with the cycle the dependent instruction sits in
  // IF/ID; this keeps the load-use penalty to a single cycle.
  assign if_src    = src_regs(if_ins[31:26], if_ins[5:0]);
  assign haz_ahead = load_en && if_valid && ex_lw_d && (ex_lw_rt_d != 5'd0) &&
                     ((if_src[1] && if_ins[25:21] == ex_lw_rt_d) ||
                      (if_src[0] && if_ins[20:16] == ex_lw_rt_d));

  always_ff @(posedge clk or negedge rst_id_n) begin
    if (!rst_id_n) state_q <= RUN;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    fetch_hold = 1'b0;
    case (state_q)
      RUN: begin
        if (haz_ahead) state_d = LU_STALL;
      end
      LU_STALL: begin
        fetch_hold = hazard && !id_flush;
        if (id_flush || !id_stall) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_id_n) begin
    if (!rst_id_n) begin
      id_ins   <= '0;
      id_valid <= 1'b0;
    end else if (id_flush) begin
      id_ins   <= '0;
      id_valid <= 1'b0;
    end else if (load_en) begin
      id_ins   <= if_ins;
      id_valid <= if_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_id_n) begin
    if (!rst_id_n) begin
      ex_lw    <= 1'b0;
      ex_lw_rt <= 5'd0;
    end else if (!id_stall) begin
      ex_lw    <= ex_lw_d;
      ex_lw_rt <= ex_lw_rt_d;
    end
  end

endmodule

// File: tb/tb_ins_decode_n32.sv
module tb_ins_decode_n32;

  logic        clk = 1'b0;
  logic        rst_id_n = 1'b0;
  logic [31:0] if_ins = '0;
  logic        if_valid = 1'b0;
  logic        id_stall = 1'b0;
  logic        id_flush = 1'b0;
  logic        fetch_hold;
  logic [31:0] id_ins;
  logic        id_valid;
  logic [4:0]  rs, rt, rd;
  logic [15:0] npc_in_imm16;
  logic [25:0] npc_in_imm26;
  logic        npc_sel, isJump, reg_write, reg_dst, alu_src;
  logic        mem_read, mem_write, mem_to_reg;
  logic [1:0]  ext_op;
  logic [2:0]  alu_op;
  logic        id_illegal;

  always #5 clk = ~clk;

  ins_decode_n32 #(.W_INS(32)) dut (
    .clk          (clk),
    .rst_id_n     (rst_id_n),
    .if_ins       (if_ins),
    .if_valid     (if_valid),
    .id_stall     (id_stall),
    .id_flush     (id_flush),
    .fetch_hold   (fetch_hold),
    .id_ins       (id_ins),
    .id_valid     (id_valid),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .npc_in_imm16 (npc_in_imm16),
    .npc_in_imm26 (npc_in_imm26),
    .npc_sel      (npc_sel),
    .isJump       (isJump),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .alu_src      (alu_src),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .ext_op       (ext_op),
    .alu_op       (alu_op),
    .id_illegal   (id_illegal)
  );

  // {npc_sel, isJump, reg_write, reg_dst, alu_src, mem_read, mem_write, mem_to_reg, ext_op, alu_op}
  logic [12:0] ctl;
  assign ctl = {npc_sel, isJump, reg_write, reg_dst, alu_src, mem_read,
                mem_write, mem_to_reg, ext_op, alu_op};

  localparam logic [12:0] C_NONE = 13'b0;
  localparam logic [12:0] C_ADDU = {8'b0011_0000, 2'd0, 3'd0};
  localparam logic [12:0] C_LW   = {8'b0010_1101, 2'd1, 3'd0};
  localparam logic [12:0] C_SW   = {8'b0000_1010, 2'd1, 3'd0};
  localparam logic [12:0] C_BEQ  = {8'b1000_0000, 2'd1, 3'd1};
  localparam logic [12:0] C_ORI  = {8'b0010_1000, 2'd0, 3'd2};
  localparam logic [12:0] C_LUI  = {8'b0010_1000, 2'd2, 3'd3};
  localparam logic [12:0] C_J    = {8'b0100_0000, 2'd0, 3'd0};

  localparam logic [31:0] I_ADDU1 = 32'h0022_1821; // rs1 rt2 rd3
  localparam logic [31:0] I_ADDU2 = 32'h0042_1821; // rs2 rt2 rd3
  localparam logic [31:0] I_ADDU3 = 32'h0043_1021; // rs2 rt3 rd2
  localparam logic [31:0] I_LW    = 32'h8C22_0004; // rt2
  localparam logic [31:0] I_LW0   = 32'h8C20_0004; // rt0
  localparam logic [31:0] I_LW2   = 32'h8C03_0008; // rs0 rt3
  localparam logic [31:0] I_BEQ   = 32'h1022_FFFE;
  localparam logic [31:0] I_ORI   = 32'h3422_0005;
  localparam logic [31:0] I_LUI   = 32'h3C01_1234;
  localparam logic [31:0] I_SW    = 32'hAC22_0008;
  localparam logic [31:0] I_J     = 32'h0800_0010;
  localparam logic [31:0] I_ILL   = 32'hFC00_0000;

`ifdef ID_ILLEGAL_TRAP_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v);
    if_ins   = ins;
    if_valid = v;
  endtask

  initial begin
    #2;
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_ins", id_ins, 32'd0);
    check("rst_ctl", 32'(ctl), 32'(C_NONE));
    check("rst_hold", 32'(fetch_hold), 32'd0);
    check("rst_ill", 32'(id_illegal), 32'd0);
    step();
    rst_id_n = 1'b1;

    drive(I_ADDU1, 1'b1); step();
    check("addu_rs", 32'(rs), 32'd1);
    check("addu_rt", 32'(rt), 32'd2);
    check("addu_rd", 32'(rd), 32'd3);
    check("addu_ctl", 32'(ctl), 32'(C_ADDU));
    check("addu_valid", 32'(id_valid), 32'd1);

    rst_id_n = 1'b0; #1;
    check("midrst_valid", 32'(id_valid), 32'd0);
    check("midrst_ins", id_ins, 32'd0);
    check("midrst_ctl", 32'(ctl), 32'(C_NONE));
    rst_id_n = 1'b1;

    // load-use: lw $2 then addu reading $2
    drive(I_LW, 1'b1); step();
    check("lu_lw_ctl", 32'(ctl), 32'(C_LW));
    check("lu_lw_hold", 32'(fetch_hold), 32'd0);
    drive(I_ADDU2, 1'b1); step();
    check("lu_stall_hold", 32'(fetch_hold), 32'd1);
    check("lu_stall_ctl", 32'(ctl), 32'(C_NONE));
    check("lu_stall_ins", id_ins, I_ADDU2);
    drive(32'h0, 1'b1); step();
    check("lu_rel_hold", 32'(fetch_hold), 32'd0);
    check("lu_rel_ctl", 32'(ctl), 32'(C_ADDU));
    check("lu_rel_rs", 32'(rs), 32'd2);

    // lw to $0 never stalls
    drive(I_LW0, 1'b1); step();
    drive(I_ADDU2, 1'b1); step();
    check("lw0_hold", 32'(fetch_hold), 32'd0);
    check("lw0_ctl", 32'(ctl), 32'(C_ADDU));

    // lw -> lw -> use: only the dependent pair stalls
    drive(I_LW, 1'b1); step();
    drive(I_LW2, 1'b1); step();
    check("lwlw_hold", 32'(fetch_hold), 32'd0);
    check("lwlw_ctl", 32'(ctl), 32'(C_LW));
    drive(I_ADDU3, 1'b1); step();
    check("lwlw_use_hold", 32'(fetch_hold), 32'd1);
    drive(32'h0, 1'b1); step();
    check("lwlw_use_ctl", 32'(ctl), 32'(C_ADDU));
    check("lwlw_use_rt", 32'(rt), 32'd3);

    drive(I_BEQ, 1'b1); step();
    check("beq_ctl", 32'(ctl), 32'(C_BEQ));
    check("beq_imm16", 32'(npc_in_imm16), 32'h0000_FFFE);
    drive(I_ORI, 1'b1); step();
    check("ori_ctl", 32'(ctl), 32'(C_ORI));
    drive(I_LUI, 1'b1); step();
    check("lui_ctl", 32'(ctl), 32'(C_LUI));
    drive(I_SW, 1'b1); step();
    check("sw_ctl", 32'(ctl), 32'(C_SW));

    drive(I_J, 1'b1); step();
    check("j_ctl", 32'(ctl), 32'(C_J));
    check("j_imm26", 32'(npc_in_imm26), 32'h0000_0010);
    id_flush = 1'b1; #1;
    check("j_flush_ctl", 32'(ctl), 32'(C_NONE));
    drive(32'h0, 1'b1); step();
    check("flush_valid", 32'(id_valid), 32'd0);
    check("flush_ins", id_ins, 32'd0);
    id_flush = 1'b0;

    // flush while in the load-use bubble
    drive(I_LW, 1'b1); step();
    drive(I_ADDU2, 1'b1); step();
    check("fh_pre_hold", 32'(fetch_hold), 32'd1);
    id_flush = 1'b1; #1;
    check("fh_flush_hold", 32'(fetch_hold), 32'd0);
    check("fh_flush_ctl", 32'(ctl), 32'(C_NONE));
    step();
    check("fh_flush_valid", 32'(id_valid), 32'd0);
    id_flush = 1'b0;
    drive(I_ADDU2, 1'b1); step();
    check("fh_after_hold", 32'(fetch_hold), 32'd0);
    check("fh_after_ctl", 32'(ctl), 32'(C_ADDU));

    // reset in the middle of a stall
    drive(I_LW, 1'b1); step();
    drive(I_ADDU2, 1'b1); step();
    check("rs_pre_hold", 32'(fetch_hold), 32'd1);
    rst_id_n = 1'b0; #1;
    check("rs_rst_hold", 32'(fetch_hold), 32'd0);
    check("rs_rst_valid", 32'(id_valid), 32'd0);
    step();
    rst_id_n = 1'b1;
    step();
    check("rs_after_valid", 32'(id_valid), 32'd1);
    check("rs_after_ctl", 32'(ctl), 32'(C_ADDU));
    check("rs_after_hold", 32'(fetch_hold), 32'd0);

    // downstream stall holds IF/ID
    drive(I_ADDU1, 1'b1); step();
    id_stall = 1'b1;
    drive(I_BEQ, 1'b1); #1;
    check("stall_ctl", 32'(ctl), 32'(C_NONE));
    step();
    check("stall_ins", id_ins, I_ADDU1);
    id_stall = 1'b0;
    step();
    check("unstall_ins", id_ins, I_BEQ);
    check("unstall_ctl", 32'(ctl), 32'(C_BEQ));

    drive(I_ADDU1, 1'b0); step();
    check("inv_valid", 32'(id_valid), 32'd0);
    check("inv_ctl", 32'(ctl), 32'(C_NONE));

    drive(I_ILL, 1'b1); step();
    check("ill_flag", 32'(id_illegal), 32'(EXP_ILL));
    check("ill_ctl", 32'(ctl), 32'(C_NONE));
    check("ill_valid", 32'(id_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
